// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ALU issue stage: ALU op codes, opcodes, buffer states and the issue entry.
package alu_issue_stage_pkg;

  localparam int ISSUE_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] BUF_EMPTY = 2'd0;
  localparam logic [1:0] BUF_ONE   = 2'd1;
  localparam logic [1:0] BUF_FULL  = 2'd2;

  // pc is the last (least significant) field so a reset entry is just RESET_PC zero-extended.
  typedef struct packed {
    logic [ISSUE_XLEN-1:0] in1;
    logic [ISSUE_XLEN-1:0] in2;
    alu_op_t               op;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [4:0]            rd;
    logic                  wb_en;
    logic                  branch;
    logic                  illegal;
    logic [ISSUE_XLEN-1:0] pc;
  } issue_entry_t;

  // Register/immediate ALU map; alt selects SUB/SRA where funct7=0100000.
  function automatic alu_op_t alu_map(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_map = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_map = ALU_SLL;
      3'b010:  alu_map = ALU_SLT;
      3'b011:  alu_map = ALU_SLTU;
      3'b100:  alu_map = ALU_XOR;
      3'b101:  alu_map = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_map = ALU_OR;
      default: alu_map = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream (fetch/regfile) and downstream (ALU) handshake bundle of the issue stage.
interface alu_issue_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_in1;
  logic [XLEN-1:0] out_in2;
  logic [3:0]      out_op;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic            out_wb_en;
  logic            out_branch;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_in1, out_in2, out_op, out_funct3, out_funct7,
           out_rd, out_wb_en, out_branch, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_in1, out_in2, out_op, out_funct3, out_funct7,
           out_rd, out_wb_en, out_branch, out_pc, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage_skid.sv
// Two-entry skid buffer (main + skid); in_ready is a function of registered state only.
module alu_issue_stage_skid
  import alu_issue_stage_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       state
);

  // Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready,
  // and out_data holds steady while out_valid && !out_ready.
  logic [1:0]       st;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             consume;

  assign in_ready  = (st != BUF_FULL);
  assign out_valid = (st != BUF_EMPTY);
  assign out_data  = main_q;
  assign state     = st;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= BUF_EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (flush) begin
      st <= BUF_EMPTY;
    end else begin
      case (st)
        BUF_EMPTY: if (accept) begin
          main_q <= in_data;
          st     <= BUF_ONE;
        end
        BUF_ONE: begin
          if (accept && !consume) begin
            skid_q <= in_data;
            st     <= BUF_FULL;
          end else if (!accept && consume) begin
            st <= BUF_EMPTY;
          end else if (accept && consume) begin
            main_q <= in_data;
          end
        end
        BUF_FULL: if (out_ready) begin
          // Older entry leaves; the skid entry becomes the head so order is preserved.
          main_q <= skid_q;
          st     <= BUF_ONE;
        end
        default: st <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes ALU op and operands, registers them to the ALU via a skid buffer.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int              XLEN     = ISSUE_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  alu_issue_stage_if.slave   bus,
  output logic [1:0]         buf_state
);

  localparam int EW = $bits(issue_entry_t);
  localparam logic [EW-1:0] RESET_ENTRY = {{(EW-XLEN){1'b0}}, RESET_PC};

  issue_entry_t dec;
  issue_entry_t cur;

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7_zero;
  logic        f7_alt;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] u_imm;
  logic [31:0] shamt;

  assign instr   = bus.in_instr;
  assign opc     = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);
  assign i_imm   = {{20{instr[31]}}, instr[31:20]};
  assign s_imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign u_imm   = {instr[31:12], 12'b0};
  assign shamt   = {27'b0, instr[24:20]};

  always_comb begin
    dec         = '0;
    dec.in1     = bus.in_rs1_data;
    dec.in2     = bus.in_rs2_data;
    dec.op      = ALU_ADD;
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.rd      = instr[11:7];
    dec.wb_en   = 1'b1;
    dec.pc      = bus.in_pc;
    case (opc)
      OPC_OP: begin
        dec.op = alu_map(f3, f7_alt);
        if (!(f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101)))) dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.in2 = i_imm;
        dec.op  = alu_map(f3, 1'b0);
        if (f3 == 3'b001) begin
          dec.in2 = shamt;
          if (!f7_zero) dec.illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          dec.in2 = shamt;
          dec.op  = alu_map(f3, f7_alt);
          if (!(f7_zero || f7_alt)) dec.illegal = 1'b1;
        end
      end
      OPC_LOAD:  dec.in2 = i_imm;
      OPC_STORE: begin
        dec.in2   = s_imm;
        dec.wb_en = 1'b0;
      end
      OPC_LUI: begin
        dec.in1 = '0;
        dec.in2 = u_imm;
      end
      OPC_AUIPC: begin
        dec.in1 = bus.in_pc;
        dec.in2 = u_imm;
      end
      OPC_JAL, OPC_JALR: begin
        dec.in1 = bus.in_pc;
        dec.in2 = 32'd4;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.wb_en  = 1'b0;
        case (f3[2:1])
          2'b00:   dec.op = ALU_SUB;
          2'b10:   dec.op = ALU_SLT;
          2'b11:   dec.op = ALU_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal instructions still flow downstream so the trap is taken in order.
    if (dec.illegal) begin
      dec.op     = ALU_ADD;
      dec.wb_en  = 1'b0;
      dec.branch = 1'b0;
    end
    if (dec.rd == 5'd0) dec.wb_en = 1'b0;
  end

  alu_issue_stage_skid #(
    .WIDTH     (EW),
    .RESET_VAL (RESET_ENTRY)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (dec),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (cur),
    .state     (buf_state)
  );

  assign bus.out_in1     = cur.in1;
  assign bus.out_in2     = cur.in2;
  assign bus.out_op      = cur.op;
  assign bus.out_funct3  = cur.funct3;
  assign bus.out_funct7  = cur.funct7;
  assign bus.out_rd      = cur.rd;
  assign bus.out_wb_en   = cur.wb_en;
  assign bus.out_branch  = cur.branch;
  assign bus.out_pc      = cur.pc;
  assign bus.out_illegal = cur.illegal;

endmodule
